// File: rtl/vram_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler_if
//   Bundles the request/response signals of the video-memory write scheduler.
//   The "slave" modport is the scheduler itself. The "master" modport is
//   whoever drives CPU writes and fill commands and observes the memory write
//   port.
//
//   CPU side    : iCpuWrite/iCpuAddr/iCpuColor in, oCpuFull/oCpuDropped out
//   Fill side   : iFillStart/iFillAbort/iFillBase/iFillWidth/iFillHeight/
//                 iFillColor in, oFillBusy/oFillDone out
//   Memory side : oVmWriteEnable/oVmWriteAddr/oVmData out (registered)
// ---------------------------------------------------------------------------
interface vram_write_scheduler_if #(
    parameter int ADDR_W  = 10,
    parameter int COLOR_W = 3
);
    // CPU write path
    logic               iCpuWrite;
    logic [ADDR_W-1:0]  iCpuAddr;
    logic [COLOR_W-1:0] iCpuColor;
    logic               oCpuFull;
    logic               oCpuDropped;

    // Rectangle fill engine
    logic               iFillStart;
    logic               iFillAbort;
    logic [ADDR_W-1:0]  iFillBase;
    logic [4:0]         iFillWidth;
    logic [4:0]         iFillHeight;
    logic [COLOR_W-1:0] iFillColor;
    logic               oFillBusy;
    logic               oFillDone;

    // Video memory write port
    logic               oVmWriteEnable;
    logic [ADDR_W-1:0]  oVmWriteAddr;
    logic [COLOR_W-1:0] oVmData;

    modport master (
        output iCpuWrite, iCpuAddr, iCpuColor,
        output iFillStart, iFillAbort, iFillBase, iFillWidth, iFillHeight, iFillColor,
        input  oCpuFull, oCpuDropped, oFillBusy, oFillDone,
        input  oVmWriteEnable, oVmWriteAddr, oVmData
    );

    modport slave (
        input  iCpuWrite, iCpuAddr, iCpuColor,
        input  iFillStart, iFillAbort, iFillBase, iFillWidth, iFillHeight, iFillColor,
        output oCpuFull, oCpuDropped, oFillBusy, oFillDone,
        output oVmWriteEnable, oVmWriteAddr, oVmData
    );
endinterface

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
//   Owns the single write port of the 32x32x3-bit video memory
//   (addr = {row[4:0], col[4:0]}) and shares it between:
//     - CPU writes, buffered in a FIFO_DEPTH-entry FIFO;
//     - a rectangle-fill engine that paints (width+1)x(height+1) cells in
//       row-major order, each coordinate wrapping within its own 5-bit field.
//   At most one memory write is issued per clock. When both sources want the
//   port, a round-robin pointer gives it to the one not served last.
//
// Ports
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous active-high reset, clears all state
//   bus  : vram_write_scheduler_if.slave (CPU, fill and memory signals)
// ---------------------------------------------------------------------------
module vram_write_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int COLOR_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    vram_write_scheduler_if.slave bus
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int COL_W   = 5;
    localparam int ROW_W   = ADDR_W - COL_W;
    localparam int ENTRY_W = ADDR_W + COLOR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // ------------------------------------------------------------------
    // CPU FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] entry_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] entry_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               dropped_q, dropped_d;

    logic               cpu_full;
    logic               cpu_push;
    logic               cpu_req;
    logic [ENTRY_W-1:0] head_entry;
    logic [ADDR_W-1:0]  head_addr;
    logic [COLOR_W-1:0] head_color;

    // Fullness is judged on the registered count only, so a pop on the same
    // edge never makes room for a push presented while full.
    assign cpu_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign cpu_push   = bus.iCpuWrite && !cpu_full;
    assign cpu_req    = (count_q != '0);
    assign head_entry = entry_q[rd_ptr_q];
    assign head_addr  = head_entry[ENTRY_W-1:COLOR_W];
    assign head_color = head_entry[COLOR_W-1:0];

    // Storage: each slot reloads only when the write pointer addresses it.
    // While count < FIFO_DEPTH the write slot is never the slot being read
    // out, so a simultaneous push and pop cannot collide.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            assign entry_d[gi] = (cpu_push && (wr_ptr_q == PTR_W'(gi)))
                               ? {bus.iCpuAddr, bus.iCpuColor}
                               : entry_q[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q[gi] <= '0;
                end else begin
                    entry_q[gi] <= entry_d[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fill engine state
    // ------------------------------------------------------------------
    fill_state_t        state_q, state_d;
    logic [ROW_W-1:0]   row0_q, row0_d;
    logic [COL_W-1:0]   col0_q, col0_d;
    logic [4:0]         width_q, width_d;
    logic [4:0]         height_q, height_d;
    logic [COLOR_W-1:0] fill_color_q, fill_color_d;
    logic [4:0]         dx_q, dx_d;
    logic [4:0]         dy_q, dy_d;
    logic               done_q, done_d;

    logic               fill_req;
    logic [ROW_W-1:0]   fill_row;
    logic [COL_W-1:0]   fill_col;

    // An abort withdraws the fill request in the same cycle, so the aborting
    // edge never issues a fill write; a CPU write can still take that slot.
    assign fill_req = (state_q == ST_FILL) && !bus.iFillAbort;

    // Row and column wrap independently: no carry from column into row.
    assign fill_row = row0_q + ROW_W'(dy_q);
    assign fill_col = col0_q + dx_q;

    // ------------------------------------------------------------------
    // Arbiter and memory write registers
    // ------------------------------------------------------------------
    logic               grant_cpu;
    logic               grant_fill;
    logic               last_fill_q, last_fill_d;
    logic               vm_we_q, vm_we_d;
    logic [ADDR_W-1:0]  vm_addr_q, vm_addr_d;
    logic [COLOR_W-1:0] vm_data_q, vm_data_d;

    // Round robin: on contention, serve whoever was not served last.
    // last_fill_q resets to 1 so the CPU wins the first contended slot.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_fill = 1'b0;
        if (cpu_req && fill_req) begin
            grant_cpu  = last_fill_q;
            grant_fill = !last_fill_q;
        end else begin
            grant_cpu  = cpu_req;
            grant_fill = fill_req;
        end
    end

    // FIFO pointer/count update and drop flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = bus.iCpuWrite && cpu_full;
        if (cpu_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (grant_cpu) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(cpu_push) - CNT_W'(grant_cpu);
    end

    // Memory write port: address/data only change on a grant, so they hold
    // their last value through idle cycles.
    always_comb begin
        vm_we_d     = grant_cpu || grant_fill;
        vm_addr_d   = vm_addr_q;
        vm_data_d   = vm_data_q;
        last_fill_d = last_fill_q;
        if (grant_cpu) begin
            vm_addr_d   = head_addr;
            vm_data_d   = head_color;
            last_fill_d = 1'b0;
        end else if (grant_fill) begin
            vm_addr_d   = {fill_row, fill_col};
            vm_data_d   = fill_color_q;
            last_fill_d = 1'b1;
        end
    end

    // Fill FSM next state. The cursor only advances on a granted fill write,
    // so losing arbitration simply retries the same cell next cycle.
    always_comb begin
        state_d      = state_q;
        row0_d       = row0_q;
        col0_d       = col0_q;
        width_d      = width_q;
        height_d     = height_q;
        fill_color_d = fill_color_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iFillStart) begin
                    state_d      = ST_FILL;
                    row0_d       = bus.iFillBase[ADDR_W-1:COL_W];
                    col0_d       = bus.iFillBase[COL_W-1:0];
                    width_d      = bus.iFillWidth;
                    height_d     = bus.iFillHeight;
                    fill_color_d = bus.iFillColor;
                    dx_d         = '0;
                    dy_d         = '0;
                end
            end
            ST_FILL: begin
                if (bus.iFillAbort) begin
                    state_d = ST_IDLE;
                end else if (grant_fill) begin
                    if (dx_q == width_q) begin
                        dx_d = '0;
                        if (dy_q == height_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            dy_d = dy_q + 5'd1;
                        end
                    end else begin
                        dx_d = dx_q + 5'd1;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dropped_q    <= 1'b0;
            state_q      <= ST_IDLE;
            row0_q       <= '0;
            col0_q       <= '0;
            width_q      <= '0;
            height_q     <= '0;
            fill_color_q <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            done_q       <= 1'b0;
            last_fill_q  <= 1'b1;
            vm_we_q      <= 1'b0;
            vm_addr_q    <= '0;
            vm_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dropped_q    <= dropped_d;
            state_q      <= state_d;
            row0_q       <= row0_d;
            col0_q       <= col0_d;
            width_q      <= width_d;
            height_q     <= height_d;
            fill_color_q <= fill_color_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            done_q       <= done_d;
            last_fill_q  <= last_fill_d;
            vm_we_q      <= vm_we_d;
            vm_addr_q    <= vm_addr_d;
            vm_data_q    <= vm_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.oCpuFull       = cpu_full;
    assign bus.oCpuDropped    = dropped_q;
    assign bus.oFillBusy      = (state_q == ST_FILL);
    assign bus.oFillDone      = done_q;
    assign bus.oVmWriteEnable = vm_we_q;
    assign bus.oVmWriteAddr   = vm_addr_q;
    assign bus.oVmData        = vm_data_q;

endmodule
